button_repeat_ctrl: RTL and testbench

//  Multi-channel press decoder with auto-repeat and acceleration for the clock-setting buttons (e.g. up/down/set).

---
 rtl/button_repeat_ctrl.sv | 132 +++++++++++++
 tb/tb_button_repeat_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_repeat_ctrl.sv
// Multi-channel button press decoder: single pulse on press, then slow and
// fast auto-repeat while held. Only one channel may own the decoder at a time.
module button_repeat_ctrl #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 24,
  parameter int unsigned FAST_TICKS   = 8,
  parameter int unsigned ACCEL_COUNT  = 10
) (
  input  logic                clk_100Hz,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] long_active,
  output logic [CHANNELS-1:0] short_release,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, PRESS, SLOW, FAST} state_t;

  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] FAST_C   = CNT_W'(FAST_TICKS);
  localparam logic [CNT_W-1:0] ACCEL_C  = CNT_W'(ACCEL_COUNT);

  state_t              state     [CHANNELS];
  logic [CNT_W-1:0]    cnt       [CHANNELS];
  logic [CNT_W-1:0]    accel     [CHANNELS];
  logic [CNT_W-1:0]    cnt_inc   [CHANNELS];
  logic [CNT_W-1:0]    accel_inc [CHANNELS];
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] grant;
  logic                armed;
  logic                found;

  // armed stays low for the first edge after reset so a button held through
  // reset is never mistaken for a fresh press.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      active[i]    = (state[i] != IDLE);
      cnt_inc[i]   = (cnt[i] == '1) ? cnt[i] : cnt[i] + 1'b1;
      accel_inc[i] = (accel[i] == '1) ? accel[i] : accel[i] + 1'b1;
      grant[i]     = enable & armed & ~busy & button[i] & ~prev[i] & ~found;
      found        = found | grant[i];
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        accel[i] <= '0;
      end
      prev          <= '0;
      armed         <= 1'b0;
      pulse         <= '0;
      long_active   <= '0;
      short_release <= '0;
      busy          <= 1'b0;
    end else begin
      prev  <= button;
      armed <= 1'b1;
      busy  <= enable & ((|grant) | (|(active & button)));
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pulse[i]         <= 1'b0;
        short_release[i] <= 1'b0;
        if (!enable) begin
          state[i]       <= IDLE;
          cnt[i]         <= '0;
          accel[i]       <= '0;
          long_active[i] <= 1'b0;
        end else begin
          case (state[i])
            IDLE: begin
              if (grant[i]) begin
                state[i] <= PRESS;
                cnt[i]   <= '0;
                pulse[i] <= 1'b1;
              end
            end
            PRESS: begin
              if (!button[i]) begin
                state[i]         <= IDLE;
                short_release[i] <= 1'b1;
              end else if (cnt_inc[i] >= LONG_C) begin
                state[i]       <= SLOW;
                cnt[i]         <= '0;
                accel[i]       <= '0;
                pulse[i]       <= 1'b1;
                long_active[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt_inc[i];
              end
            end
            SLOW: begin
              if (!button[i]) begin
                state[i]       <= IDLE;
                long_active[i] <= 1'b0;
              end else if (cnt_inc[i] >= REPEAT_C) begin
                cnt[i]   <= '0;
                pulse[i] <= 1'b1;
                accel[i] <= accel_inc[i];
                if (accel_inc[i] >= ACCEL_C) state[i] <= FAST;
              end else begin
                cnt[i] <= cnt_inc[i];
              end
            end
            FAST: begin
              if (!button[i]) begin
                state[i]       <= IDLE;
                long_active[i] <= 1'b0;
              end else if (cnt_inc[i] >= FAST_C) begin
                cnt[i]   <= '0;
                pulse[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt_inc[i];
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Bench for button_repeat_ctrl: directed scenarios plus random button traffic,
// all compared each cycle against a hold-time based model.
module tb_button_repeat_ctrl;

  localparam int L = 100;
  localparam int R = 24;
  localparam int F = 8;
  localparam int A = 3;

  logic       clk_100Hz = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] button;
  logic [1:0] pulse;
  logic [1:0] long_active;
  logic [1:0] short_release;
  logic       busy;

  button_repeat_ctrl #(
    .CHANNELS(2), .CNT_W(10), .LONG_TICKS(L), .REPEAT_TICKS(R),
    .FAST_TICKS(F), .ACCEL_COUNT(A)
  ) dut (
    .clk_100Hz(clk_100Hz), .rst_n(rst_n), .enable(enable), .button(button),
    .pulse(pulse), .long_active(long_active), .short_release(short_release),
    .busy(busy)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model: owner channel and edges held since its accepted press
  int         owner;
  int         h;
  logic [1:0] m_prev;
  bit         m_armed;
  logic [1:0] e_pulse, e_long, e_sr;
  logic       e_busy;

  function automatic bit is_pulse(int hh);
    if (hh == 0 || hh == L) return 1'b1;
    if (hh > L && hh <= L + A*R) return ((hh - L) % R) == 0;
    if (hh > L + A*R) return ((hh - L - A*R) % F) == 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    owner = -1; h = 0; m_prev = '0; m_armed = 1'b0;
    e_pulse = '0; e_long = '0; e_sr = '0; e_busy = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [1:0] btn);
    e_pulse = '0; e_long = '0; e_sr = '0;
    if (!en) begin
      owner = -1;
    end else if (owner >= 0) begin
      if (!btn[owner]) begin
        if (h < L) e_sr[owner] = 1'b1;
        owner = -1;
      end else begin
        h++;
        e_pulse[owner] = is_pulse(h);
        e_long[owner]  = (h >= L);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (owner < 0 && btn[i] && !m_prev[i] && m_armed) begin
          owner = i; h = 0; e_pulse[i] = 1'b1;
        end
      end
    end
    m_prev = btn; m_armed = 1'b1;
    e_busy = (owner >= 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pulse", 32'(pulse), 32'(e_pulse));
    chk("long_active", 32'(long_active), 32'(e_long));
    chk("short_release", 32'(short_release), 32'(e_sr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pulse_onehot", 32'($countones(pulse) <= 1), 32'd1);
  endtask

  task automatic tick(input logic en, input logic [1:0] btn);
    enable = en; button = btn;
    model_edge(en, btn);
    @(posedge clk_100Hz);
    #1;
    cyc++;
    check_outputs();
  endtask

  int q[$];
  int exp_c[8] = '{1, 101, 125, 149, 173, 181, 189, 197};
  int n;
  logic       r_en;
  logic [1:0] r_btn;
  int         r_left[2];

  initial begin
    rst_n = 1'b0; enable = 1'b0; button = '0;
    model_reset();
    #12;
    chk("reset_pulse", 32'(pulse), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk_100Hz); #1;
    rst_n = 1'b1;
    tick(1'b1, 2'b00);

    // short press
    cyc = 0;
    tick(1'b1, 2'b01);
    chk("t1_first_pulse", 32'(pulse), 32'd1);
    repeat (4) tick(1'b1, 2'b01);
    tick(1'b1, 2'b00);
    chk("t1_short_release", 32'(short_release), 32'd1);
    chk("t1_long", 32'(long_active), 32'd0);
    tick(1'b1, 2'b00);

    // long hold into fast repeat
    cyc = 0; q.delete();
    repeat (199) begin
      tick(1'b1, 2'b01);
      if (pulse[0]) q.push_back(cyc);
      if (cyc == 100) chk("t2_long_before", 32'(long_active), 32'd0);
      if (cyc == 101) chk("t2_long_entry", 32'(long_active), 32'd1);
    end
    chk("t2_pulse_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) chk("t2_pulse_cycle", 32'(q[i]), 32'(exp_c[i]));
    tick(1'b1, 2'b00);
    chk("t2_release_long", 32'(long_active), 32'd0);
    chk("t2_release_sr", 32'(short_release), 32'd0);
    tick(1'b1, 2'b00);

    // simultaneous press: ch0 wins, held ch1 never self-starts
    tick(1'b1, 2'b11);
    chk("t3_winner", 32'(pulse), 32'd1);
    repeat (5) tick(1'b1, 2'b11);
    n = 0;
    repeat (6) begin
      tick(1'b1, 2'b10);
      if (pulse[1]) n++;
    end
    chk("t3_loser_quiet", 32'(n), 32'd0);
    tick(1'b1, 2'b00);
    tick(1'b1, 2'b10);
    chk("t3_repress", 32'(pulse), 32'd2);
    tick(1'b1, 2'b00);

    // release exactly as a slow period expires
    cyc = 0;
    repeat (124) tick(1'b1, 2'b01);
    tick(1'b1, 2'b00);
    chk("t4_no_pulse", 32'(pulse), 32'd0);
    chk("t4_no_sr", 32'(short_release), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    tick(1'b1, 2'b00);

    // enable abort mid-fast, re-enable with button held
    repeat (185) tick(1'b1, 2'b01);
    tick(1'b0, 2'b01);
    chk("t5_abort_long", 32'(long_active), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    repeat (3) tick(1'b0, 2'b01);
    n = 0;
    repeat (30) begin
      tick(1'b1, 2'b01);
      if (pulse != 2'b00) n++;
    end
    chk("t5_held_quiet", 32'(n), 32'd0);
    tick(1'b1, 2'b00);
    tick(1'b1, 2'b01);
    chk("t5_repress", 32'(pulse), 32'd1);
    tick(1'b1, 2'b00);

    // asynchronous reset mid-slow
    repeat (130) tick(1'b1, 2'b01);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_long", 32'(long_active), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(posedge clk_100Hz); #1;
    check_outputs();
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      tick(1'b1, 2'b01);
      if (pulse != 2'b00) n++;
    end
    chk("t6_held_quiet", 32'(n), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick(1'b1, 2'b00);
    tick(1'b1, 2'b01);
    chk("t6_repress", 32'(pulse), 32'd1);
    tick(1'b1, 2'b00);

    // random traffic
    r_en = 1'b1; r_btn = '0;
    r_left[0] = 5; r_left[1] = 9;
    repeat (5000) begin
      if (r_en) begin
        if ($urandom_range(0, 599) == 0) r_en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        r_en = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        r_left[i]--;
        if (r_left[i] <= 0) begin
          r_btn[i]  = ~r_btn[i];
          r_left[i] = r_btn[i] ? int'($urandom_range(1, 260)) : int'($urandom_range(1, 30));
        end
      end
      tick(r_en, r_btn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
